// File: rtl/fir_response_capture.sv
// Captures DEPTH filter samples after the first non-zero valid sample, then reads them out via valid/ready.
// Optional FIR_CAP_SUM_EN adds cap_sum, the unsigned running sum of the stored samples.
module fir_response_capture #(
  parameter int N       = 16,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             data_in,
  input  logic                     sample_valid,
  input  logic                     arm,
  input  logic                     abort,
  output logic [N-1:0]             rd_data,
  output logic [$clog2(DEPTH)-1:0] rd_index,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout
`ifdef FIR_CAP_SUM_EN
  ,
  output logic [N+$clog2(DEPTH)-1:0] cap_sum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ZERO_A = '0;
  localparam logic [TW-1:0] TLAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_idx_q, wr_idx_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [AW-1:0]   rd_next;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [N-1:0]    rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            we;
  logic [AW-1:0]   wa;

  logic [N-1:0]    mem [DEPTH];

`ifdef FIR_CAP_SUM_EN
  logic [N+AW-1:0] sum_q, sum_d;
`endif

  assign rd_next = rd_idx_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    tcnt_d     = tcnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    timeout_d  = timeout_q;
    done_d     = 1'b0;
    we         = 1'b0;
    wa         = wr_idx_q;
`ifdef FIR_CAP_SUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (arm && !abort) begin
          state_d   = ARMED;
          timeout_d = 1'b0;
          wr_idx_d  = '0;
          tcnt_d    = '0;
`ifdef FIR_CAP_SUM_EN
          sum_d     = '0;
`endif
        end
      end
      ARMED: begin
        if (sample_valid && (data_in != '0)) begin
          we       = 1'b1;
          wa       = ZERO_A;
          wr_idx_d = AW'(1);
          state_d  = CAPTURE;
        end else if (tcnt_q == TLAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          we       = 1'b1;
          wr_idx_d = wr_idx_q + AW'(1);
          // Slot 0 was written while ARMED, so it can be fetched alongside the final store.
          if (wr_idx_q == LAST) begin
            state_d    = READOUT;
            rd_idx_d   = '0;
            rd_valid_d = 1'b1;
            rd_data_d  = mem[ZERO_A];
          end
        end
      end
      READOUT: begin
        if (rd_valid_q && rd_ready) begin
          if (rd_idx_q == LAST) begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            rd_idx_d  = rd_next;
            rd_data_d = mem[rd_next];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      we         = 1'b0;
    end
`ifdef FIR_CAP_SUM_EN
    if (we) sum_d = sum_q + (N+AW)'(data_in);
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      tcnt_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      tcnt_q     <= tcnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  // Buffer survives reset and abort; rd_valid alone marks its contents as meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= data_in;
  end

`ifdef FIR_CAP_SUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum_q <= '0;
    else        sum_q <= sum_d;
  end
  assign cap_sum = sum_q;
`endif

  assign rd_data  = rd_data_q;
  assign rd_index = rd_idx_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_fir_response_capture.sv
// Directed bench for fir_response_capture: impulse, backpressure, timeout, gaps, abort and async reset.
module tb_fir_response_capture;
  localparam int N       = 16;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int AW      = 4;

  logic          clk;
  logic          reset;
  logic [N-1:0]  data_in;
  logic          sample_valid;
  logic          arm;
  logic          abort;
  logic [N-1:0]  rd_data;
  logic [AW-1:0] rd_index;
  logic          rd_valid;
  logic          rd_ready;
  logic          busy;
  logic          done;
  logic          timeout;
`ifdef FIR_CAP_SUM_EN
  logic [N+AW-1:0] cap_sum;
`endif

  int checks = 0;
  int errors = 0;
  logic [N-1:0] stim[$];
  logic [N-1:0] expq[$];

  fir_response_capture #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sample_valid(sample_valid),
    .arm(arm), .abort(abort), .rd_data(rd_data), .rd_index(rd_index),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy), .done(done),
    .timeout(timeout)
`ifdef FIR_CAP_SUM_EN
    , .cap_sum(cap_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic feed();
    foreach (stim[i]) begin
      data_in      = stim[i];
      sample_valid = 1'b1;
      step();
    end
    sample_valid = 1'b0;
    data_in      = '0;
  endtask

  task automatic readout_all(input string tag);
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk({tag, "_rv"}, 32'(rd_valid), 32'd1);
      chk({tag, "_idx"}, 32'(rd_index), 32'(i));
      chk({tag, "_data"}, 32'(rd_data), 32'(expq[i]));
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      $display("%s transfer idx=%0d data=0x%0h", tag, rd_index, rd_data);
      step();
    end
    rd_ready = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_rv_end"}, 32'(rd_valid), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    step();
    chk({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    int exp_idx;
    int seen_rv;
    reset = 1'b0; data_in = '0; sample_valid = 1'b0;
    arm = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    #12;
    chk("rst_rv", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_idx", 32'(rd_index), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // arm and abort together: abort wins
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    chk("collide_busy", 32'(busy), 32'd0);
    $display("collision arm+abort busy=%0d", busy);

    // impulse: 0,0,1..16
    arm_pulse();
    chk("imp_busy", 32'(busy), 32'd1);
    stim = {16'd0, 16'd0};
    for (int v = 1; v <= 16; v++) stim.push_back(16'(v));
    feed();
`ifdef FIR_CAP_SUM_EN
    chk("imp_sum", 32'(cap_sum), 32'd136);
`endif
    expq.delete();
    for (int v = 1; v <= 16; v++) expq.push_back(16'(v));
    readout_all("imp");

    // backpressure with rd_ready 1,0,0 repeating
    arm_pulse();
    stim.delete(); expq.delete();
    for (int i = 0; i < 16; i++) begin
      stim.push_back(16'(i * 3 + 7));
      expq.push_back(16'(i * 3 + 7));
    end
    feed();
    exp_idx = 0;
    for (int cyc = 0; cyc < 100 && exp_idx < DEPTH; cyc++) begin
      rd_ready = (cyc % 3 == 0);
      chk("bp_rv", 32'(rd_valid), 32'd1);
      chk("bp_idx", 32'(rd_index), 32'(exp_idx));
      chk("bp_data", 32'(rd_data), 32'(expq[exp_idx]));
      $display("bp cyc=%0d ready=%0d idx=%0d data=0x%0h", cyc, rd_ready, rd_index, rd_data);
      if (rd_ready) exp_idx++;
      step();
    end
    rd_ready = 1'b0;
    chk("bp_count", 32'(exp_idx), 32'd16);
    chk("bp_done", 32'(done), 32'd1);

    // timeout: zeros never trigger
    arm_pulse();
    seen_rv = 0;
    data_in = '0; sample_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (rd_valid) seen_rv++;
      if (c == 7) chk("to_busy7", 32'(busy), 32'd1);
      if (c == 8) begin
        chk("to_busy8", 32'(busy), 32'd0);
        chk("to_flag8", 32'(timeout), 32'd1);
      end
      $display("timeout cyc=%0d busy=%0d timeout=%0d", c, busy, timeout);
    end
    sample_valid = 1'b0;
    chk("to_sticky", 32'(timeout), 32'd1);
    chk("to_no_rv", 32'(seen_rv), 32'd0);

    // gapped capture after trigger value 5
    arm_pulse();
    chk("gap_to_clr", 32'(timeout), 32'd0);
    expq.delete();
    expq.push_back(16'd5);
    data_in = '0; sample_valid = 1'b1; step();
    data_in = 16'd5; step();
    for (int k = 1; k <= 15; k++) begin
      sample_valid = 1'b0; data_in = 16'hdead; step();
      sample_valid = 1'b1; data_in = 16'(k * 7); step();
      expq.push_back(16'(k * 7));
    end
    sample_valid = 1'b0; data_in = '0;
    readout_all("gap");

    // abort during readout at index 7
    arm_pulse();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(16'(100 + i));
    feed();
    rd_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("abt_idx7", 32'(rd_index), 32'd7);
    chk("abt_data7", 32'(rd_data), 32'd107);
    rd_ready = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abt_rv", 32'(rd_valid), 32'd0);
    chk("abt_busy", 32'(busy), 32'd0);
    chk("abt_done", 32'(done), 32'd0);
    step();
    chk("abt_done2", 32'(done), 32'd0);
    $display("abort at idx 7 rd_valid=%0d done=%0d", rd_valid, done);

    // async reset mid-capture
    arm_pulse();
    stim = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    feed();
    chk("ar_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_rv", 32'(rd_valid), 32'd0);
    chk("ar_idx", 32'(rd_index), 32'd0);
    chk("ar_data", 32'(rd_data), 32'd0);
    $display("async reset busy=%0d rd_valid=%0d", busy, rd_valid);
    arm = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    step();
    arm = 1'b0;
    chk("ar_first_arm", 32'(busy), 32'd1);
    chk("ar_no_done", 32'(done), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ar_abort_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_response_capture.md
FIR_RESPONSE_CAPTURE -- requirements
Module: fir_response_capture

Interface
REQ-001 SHALL have parameter N, default 16, sample width in bits (matches FIR_Filter data_out).
REQ-002 SHALL have parameter DEPTH, default 16, number of captured samples (power of two, 2..256).
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum ARMED cycles before giving up.
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data_in  input  N  filter output sample (driven from FIR_Filter data_out).
REQ-007 SHALL have port sample_valid  input  1  data_in carries a new sample this cycle.
REQ-008 SHALL have port arm  input  1  one-cycle request to start a capture.
REQ-009 SHALL have port abort  input  1  return to IDLE from any state.
REQ-010 SHALL have port rd_data  output  N  captured sample presented for readout.
REQ-011 SHALL have port rd_index  output  $clog2(DEPTH)  buffer index of rd_data.
REQ-012 SHALL have port rd_valid  output  1  rd_data/rd_index valid.
REQ-013 SHALL have port rd_ready  input  1  consumer accepts rd_data.
REQ-014 SHALL have ports busy, done, timeout  output  1 each  status (state != IDLE; end-of-readout pulse; sticky no-trigger flag).

Function
REQ-015 SHALL implement FSM states IDLE, ARMED, CAPTURE, READOUT.
REQ-016 IDLE: arm=1 and abort=0 -> ARMED next cycle, clearing timeout flag and write index; arm ignored in every other state.
REQ-017 ARMED: first cycle with sample_valid=1 and data_in!=0 SHALL write that sample to buffer[0] and go to CAPTURE with write index 1.
REQ-018 ARMED: zero-valued or invalid samples SHALL NOT be stored; after TIMEOUT consecutive ARMED cycles without trigger -> IDLE with timeout=1.
REQ-019 CAPTURE: every sample_valid=1 cycle SHALL store data_in (including zeros) at write index and increment it; cycles with sample_valid=0 store nothing.
REQ-020 CAPTURE: store at index DEPTH-1 SHALL move to READOUT; read index starts at 0.
REQ-021 READOUT: rd_valid=1 with rd_data=buffer[rd_index]; transfer occurs when rd_valid and rd_ready both 1 in a cycle.
REQ-022 rd_data and rd_index SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-023 Transfer of index DEPTH-1 SHALL go to IDLE and assert done for exactly one cycle the next cycle; rd_valid=0 that same cycle.
REQ-024 Back-to-back transfers SHALL sustain one sample per cycle with rd_ready held high.
REQ-025 abort=1 in any state SHALL go to IDLE next cycle, deassert rd_valid, no done pulse; abort beats arm when simultaneous.
REQ-026 Outputs SHALL be registered; rd_valid, busy, done, timeout are 0 whenever the FSM is in IDLE except the done pulse of REQ-023.
REQ-027 Buffer contents SHALL not be cleared by abort or reset; only rd_valid gating defines validity.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, indices 0, rd_data 0, rd_valid/busy/done/timeout 0.
REQ-029 Reset mid-CAPTURE or mid-READOUT SHALL discard the capture; no done pulse on release.
REQ-030 First arm SHALL be honoured on the first rising edge after reset deasserts.

Configuration
REQ-031 Macro FIR_CAP_SUM_EN defined: SHALL add output cap_sum, width N+$clog2(DEPTH), unsigned running sum of stored samples, cleared on arm, valid (final) from READOUT entry until next arm.
REQ-032 FIR_CAP_SUM_EN undefined: cap_sum port and adder SHALL be absent; all other behaviour identical.

Verification
REQ-033 Impulse: reset, arm, data_in stream 0,0,1,2,3,...,16 all valid -> buffer reads 1..16 at rd_index 0..15, done pulse once, cap_sum=136 when enabled.
REQ-034 Backpressure: rd_ready toggling 1,0,0,1... -> rd_data/rd_index held during stalls, 16 transfers, no duplicates or skips.
REQ-035 Timeout: TIMEOUT=8, arm, data_in=0 for 10 cycles -> IDLE after 8 ARMED cycles, timeout=1, rd_valid never asserted.
REQ-036 Gapped capture: sample_valid low every other cycle after trigger value 5 -> only valid samples stored, 16 entries, first =5.
REQ-037 Abort/arm collision: arm and abort high together in IDLE -> stays IDLE; abort during READOUT at index 7 -> rd_valid=0 next cycle, no done.
REQ-038 Async reset: reset=0 mid-edge during CAPTURE -> all outputs 0 immediately, not after a clock edge.
